// File: rtl/vigna_irq_ctrl_if.sv
// Bus bundle between the vigna core's memory port and the interrupt controller.
// Latency: none (wires only).
// Backpressure: master holds bus_valid and its payload until the slave returns a one-cycle bus_ready.
//
// Signals:
//   bus_valid  request, held high until bus_ready
//   bus_ready  one-cycle completion pulse
//   bus_addr   byte address, only [4:2] decoded by the slave
//   bus_wdata  write data
//   bus_wstrb  byte enables, nonzero = write, zero = read
//   bus_rdata  read data, valid while bus_ready = 1
interface vigna_irq_ctrl_if;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_addr, bus_wdata, bus_wstrb,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/vigna_irq_ctrl.sv
// Interrupt controller for the vigna core: NUM_SRC level/edge sources with enable,
// claim/complete, machine software interrupt and an optional 64-bit machine timer.
// Latency: every bus access completes with bus_ready one cycle after bus_valid is sampled.
// Backpressure: none beyond the handshake; one access per request, no queueing.
//
// Ports:
//   clk, resetn      single clock, asynchronous active-low reset
//   src_irq          external interrupt lines (synchronous to clk)
//   bus              slave side of vigna_irq_ctrl_if
//   ext_irq          registered |(pending & enable)
//   timer_irq        registered (mtime >= mtimecmp), 0 when the timer is not built
//   soft_irq         MSIP bit 0
//
// Build option: define VIGNA_IRQ_TIMER_EN to include MTIME/MTIMECMP (word indices 4-7);
// without it those indices read 0 and ignore writes.
module vigna_irq_ctrl #(
    parameter int unsigned              NUM_SRC   = 8,
    parameter logic [NUM_SRC-1:0]       EDGE_MASK = '0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_SRC-1:0]   src_irq,
    vigna_irq_ctrl_if.slave      bus,
    output logic                 ext_irq,
    output logic                 timer_irq,
    output logic                 soft_irq
);

    localparam logic [2:0] IDX_PENDING  = 3'd0;
    localparam logic [2:0] IDX_ENABLE   = 3'd1;
    localparam logic [2:0] IDX_CLAIM    = 3'd2;
    localparam logic [2:0] IDX_MSIP     = 3'd3;
`ifdef VIGNA_IRQ_TIMER_EN
    localparam logic [2:0] IDX_MTIME_LO = 3'd4;
    localparam logic [2:0] IDX_MTIME_HI = 3'd5;
    localparam logic [2:0] IDX_CMP_LO   = 3'd6;
    localparam logic [2:0] IDX_CMP_HI   = 3'd7;
`endif

    logic [NUM_SRC-1:0] pending, pending_d;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] in_service, in_service_d;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] claim_hot, claim_set, cmp_clr;
    logic [4:0]         claim_id;
    logic               msip;
    logic               ext_irq_q;
    logic               ready_q;
    logic [31:0]        rdata_q, rd_val;
    logic               armed;

    logic               access, is_wr, claim_rd, complete_wr;
    logic [2:0]         idx;
    logic [31:0]        wmask, en_merged;

    logic               unused_addr;
    assign unused_addr = ^{bus.bus_addr[31:5], bus.bus_addr[1:0]};

    // armed holds off the first edge after reset release so that the earliest
    // possible access lands on the second edge.
    assign access      = armed && bus.bus_valid && !ready_q;
    assign is_wr       = |bus.bus_wstrb;
    assign idx         = bus.bus_addr[4:2];
    assign claim_rd    = access && !is_wr && (idx == IDX_CLAIM);
    assign complete_wr = access &&  is_wr && (idx == IDX_CLAIM);
    assign wmask       = {{8{bus.bus_wstrb[3]}}, {8{bus.bus_wstrb[2]}},
                          {8{bus.bus_wstrb[1]}}, {8{bus.bus_wstrb[0]}}};
    assign en_merged   = (32'(enable) & ~wmask) | (bus.bus_wdata & wmask);
    assign active      = pending & enable;

    // Lowest-numbered active source wins: scan downwards so the last hit is the lowest.
    always_comb begin
        claim_id  = '0;
        claim_hot = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                claim_id     = 5'(i + 1);
                claim_hot    = '0;
                claim_hot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        claim_set = claim_rd ? claim_hot : '0;
        cmp_clr   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cmp_clr[i] = complete_wr && (bus.bus_wdata[4:0] == 5'(i + 1));
        end
        // Completing an id that is not in service clears an already-clear bit.
        in_service_d = (in_service | claim_set) & ~cmp_clr;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (EDGE_MASK[i]) begin
                // A new rising edge outranks a claim on the same cycle.
                pending_d[i] = (src_irq[i] & ~src_q[i]) | (pending[i] & ~claim_set[i]);
            end else begin
                pending_d[i] = src_irq[i] & ~in_service_d[i];
            end
        end
    end

`ifdef VIGNA_IRQ_TIMER_EN
    logic [63:0] mtime, mtime_d;
    logic [63:0] mtimecmp, mtimecmp_d;
    logic        timer_q;

    // A write to either mtime half replaces the increment for that cycle.
    always_comb begin
        mtime_d    = mtime + 64'd1;
        mtimecmp_d = mtimecmp;
        if (access && is_wr) begin
            case (idx)
                IDX_MTIME_LO: mtime_d = {mtime[63:32],
                                         (mtime[31:0] & ~wmask) | (bus.bus_wdata & wmask)};
                IDX_MTIME_HI: mtime_d = {(mtime[63:32] & ~wmask) | (bus.bus_wdata & wmask),
                                         mtime[31:0]};
                IDX_CMP_LO:   mtimecmp_d = {mtimecmp[63:32],
                                            (mtimecmp[31:0] & ~wmask) | (bus.bus_wdata & wmask)};
                IDX_CMP_HI:   mtimecmp_d = {(mtimecmp[63:32] & ~wmask) | (bus.bus_wdata & wmask),
                                            mtimecmp[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mtime    <= '0;
            mtimecmp <= '1;
            timer_q  <= 1'b0;
        end else begin
            mtime    <= mtime_d;
            mtimecmp <= mtimecmp_d;
            timer_q  <= (mtime >= mtimecmp);
        end
    end

    assign timer_irq = timer_q;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        case (idx)
            IDX_PENDING:  rd_val = 32'(pending);
            IDX_ENABLE:   rd_val = 32'(enable);
            IDX_CLAIM:    rd_val = {27'd0, claim_id};
            IDX_MSIP:     rd_val = {31'd0, msip};
`ifdef VIGNA_IRQ_TIMER_EN
            IDX_MTIME_LO: rd_val = mtime[31:0];
            IDX_MTIME_HI: rd_val = mtime[63:32];
            IDX_CMP_LO:   rd_val = mtimecmp[31:0];
            IDX_CMP_HI:   rd_val = mtimecmp[63:32];
`endif
            default:      rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            armed      <= 1'b0;
            pending    <= '0;
            enable     <= '0;
            in_service <= '0;
            src_q      <= '0;
            msip       <= 1'b0;
            ext_irq_q  <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            armed      <= 1'b1;
            pending    <= pending_d;
            in_service <= in_service_d;
            src_q      <= src_irq;
            ext_irq_q  <= |active;
            ready_q    <= access;
            rdata_q    <= (access && !is_wr) ? rd_val : 32'd0;
            if (access && is_wr && (idx == IDX_ENABLE)) begin
                enable <= en_merged[NUM_SRC-1:0];
            end
            if (access && is_wr && (idx == IDX_MSIP) && bus.bus_wstrb[0]) begin
                msip <= bus.bus_wdata[0];
            end
        end
    end

    assign bus.bus_ready = ready_q;
    assign bus.bus_rdata = rdata_q;
    assign ext_irq       = ext_irq_q;
    assign soft_irq      = msip;

endmodule

// File: tb/tb_vigna_irq_ctrl.sv
module tb_vigna_irq_ctrl;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] src_irq = '0;
    logic       ext_irq, timer_irq, soft_irq;

    vigna_irq_ctrl_if bus();

    vigna_irq_ctrl #(.NUM_SRC(8), .EDGE_MASK(8'h01)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .src_irq   (src_irq),
        .bus       (bus),
        .ext_irq   (ext_irq),
        .timer_irq (timer_irq),
        .soft_irq  (soft_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    // Scoreboard monitor: every completed access pops one entry; reads are compared.
    always @(negedge clk) begin
        if (resetn && bus.bus_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ready: bus_ready=1 with no request outstanding, required 0");
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.chk) begin
                    n_vec++;
                    if (bus.bus_rdata !== mon_e.exp) begin
                        n_err++;
                        $display("FAIL %s: rdata=%h required %h", mon_e.name, bus.bus_rdata, mon_e.exp);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_xfer(input logic [2:0] idx, input logic [31:0] wdata, input logic [3:0] wstrb,
                            input logic chk, input logic [31:0] exp, input string name,
                            input logic [7:0] pulse);
        bit got = 1'b0;
        sb.push_back('{chk, exp, name});
        bus.bus_addr  = {27'd0, idx, 2'b00};
        bus.bus_wdata = wdata;
        bus.bus_wstrb = wstrb;
        bus.bus_valid = 1'b1;
        src_irq       = src_irq | pulse;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk);
            #1;
            src_irq = src_irq & ~pulse;
            if (bus.bus_ready) got = 1'b1;
        end
        bus.bus_valid = 1'b0;
        bus.bus_wstrb = 4'h0;
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: no bus_ready within 20 cycles, required one", name);
            if (sb.size() > 0) void'(sb.pop_back());
        end
    endtask

    task automatic rd(input logic [2:0] idx, input logic [31:0] exp, input string name);
        bus_xfer(idx, 32'd0, 4'h0, 1'b1, exp, name, 8'h00);
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] strb);
        bus_xfer(idx, data, strb, 1'b0, 32'd0, "write", 8'h00);
    endtask

    task automatic pulse_src0();
        src_irq[0] = 1'b1;
        cycles(1);
        src_irq[0] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100us, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.bus_valid = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        bus.bus_wstrb = '0;
        #1;
        check("reset_ext_irq",   {31'd0, ext_irq},       32'd0);
        check("reset_soft_irq",  {31'd0, soft_irq},      32'd0);
        check("reset_timer_irq", {31'd0, timer_irq},     32'd0);
        check("reset_ready",     {31'd0, bus.bus_ready}, 32'd0);
        cycles(2);
        resetn = 1'b1;
        cycles(2);

        // Dirty some state, then reset in the middle of an outstanding read.
        wr(3'd1, 32'hFF, 4'hF);
        wr(3'd3, 32'h1, 4'hF);
        check("pre_reset_soft", {31'd0, soft_irq}, 32'd1);
        cycles(2);
        bus.bus_addr  = {27'd0, 3'd1, 2'b00};
        bus.bus_wstrb = 4'h0;
        bus.bus_valid = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check("abort_ready",     {31'd0, bus.bus_ready}, 32'd0);
        check("abort_soft_irq",  {31'd0, soft_irq},      32'd0);
        check("abort_ext_irq",   {31'd0, ext_irq},       32'd0);
        bus.bus_valid = 1'b0;
        cycles(2);
        check("abort_no_ready",  {31'd0, bus.bus_ready}, 32'd0);
        resetn = 1'b1;

        rd(3'd0, 32'd0, "rst_pending");
        rd(3'd1, 32'd0, "rst_enable");
        rd(3'd2, 32'd0, "rst_claim");
        rd(3'd3, 32'd0, "rst_msip");
`ifdef VIGNA_IRQ_TIMER_EN
        rd(3'd5, 32'd0, "rst_mtime_hi");
        rd(3'd6, 32'hFFFF_FFFF, "rst_mtimecmp_lo");
        rd(3'd7, 32'hFFFF_FFFF, "rst_mtimecmp_hi");
`else
        rd(3'd4, 32'd0, "rst_idx4");
        rd(3'd5, 32'd0, "rst_idx5");
        rd(3'd6, 32'd0, "rst_idx6");
        rd(3'd7, 32'd0, "rst_idx7");
`endif

        // Priority and claim/complete on level sources 2 and 5.
        wr(3'd1, 32'hFF, 4'hF);
        src_irq = 8'h24;
        cycles(3);
        check("prio_ext_irq", {31'd0, ext_irq}, 32'd1);
        rd(3'd0, 32'h24, "prio_pending");
        rd(3'd2, 32'd3,  "prio_claim_first");
        rd(3'd2, 32'd6,  "prio_claim_second");
        rd(3'd0, 32'h00, "prio_pending_in_service");
        wr(3'd2, 32'd9, 4'hF);
        rd(3'd0, 32'h00, "prio_bad_complete");
        wr(3'd2, 32'd3, 4'hF);
        rd(3'd0, 32'h04, "prio_reassert");
        src_irq = 8'h00;
        wr(3'd2, 32'd6, 4'hF);
        cycles(2);
        rd(3'd0, 32'h00, "prio_idle");
        cycles(2);
        check("prio_ext_low", {31'd0, ext_irq}, 32'd0);

        // Edge-triggered source 0.
        pulse_src0();
        cycles(2);
        rd(3'd0, 32'h01, "edge_pend");
        cycles(5);
        rd(3'd0, 32'h01, "edge_hold");
        rd(3'd2, 32'd1,  "edge_claim");
        rd(3'd0, 32'h00, "edge_cleared");
        pulse_src0();
        cycles(2);
        rd(3'd0, 32'h01, "edge_repend_in_service");
        rd(3'd2, 32'd1,  "edge_claim_again");
        wr(3'd2, 32'd1, 4'hF);
        pulse_src0();
        cycles(2);
        bus_xfer(3'd2, 32'd0, 4'h0, 1'b1, 32'd1, "edge_claim_with_pulse", 8'h01);
        rd(3'd0, 32'h01, "edge_set_wins");
        rd(3'd2, 32'd1,  "edge_final_claim");
        wr(3'd2, 32'd1, 4'hF);
        rd(3'd0, 32'h00, "edge_done");

        // Masking with level source 4.
        wr(3'd1, 32'h0, 4'hF);
        src_irq = 8'h10;
        cycles(3);
        rd(3'd0, 32'h10, "mask_pending");
        check("mask_ext_off", {31'd0, ext_irq}, 32'd0);
        rd(3'd2, 32'd0, "mask_claim_none");
        wr(3'd1, 32'h10, 4'hF);
        check("mask_ext_same_cycle", {31'd0, ext_irq}, 32'd0);
        cycles(1);
        check("mask_ext_next_cycle", {31'd0, ext_irq}, 32'd1);
        wr(3'd1, 32'hFFFF_FFFF, 4'b0010);
        rd(3'd1, 32'h10, "enable_lane1_ignored");
        wr(3'd1, 32'hFFFF_FFFF, 4'b0001);
        rd(3'd1, 32'hFF, "enable_upper_zero");
        src_irq = 8'h00;
        cycles(3);
        check("mask_ext_drop", {31'd0, ext_irq}, 32'd0);

        // Software interrupt.
        wr(3'd3, 32'h1, 4'hF);
        check("msip_set", {31'd0, soft_irq}, 32'd1);
        rd(3'd3, 32'h1, "msip_read");
        wr(3'd3, 32'h0, 4'b0010);
        check("msip_lane1_ignored", {31'd0, soft_irq}, 32'd1);
        wr(3'd3, 32'h0, 4'b0001);
        check("msip_clear", {31'd0, soft_irq}, 32'd0);
        rd(3'd3, 32'h0, "msip_read_clear");

`ifdef VIGNA_IRQ_TIMER_EN
        wr(3'd7, 32'h0, 4'hF);
        wr(3'd5, 32'h0, 4'hF);
        wr(3'd4, 32'h10, 4'hF);
        wr(3'd6, 32'h20, 4'hF);
        check("timer_early", {31'd0, timer_irq}, 32'd0);
        cycles(6);
        check("timer_not_yet", {31'd0, timer_irq}, 32'd0);
        cycles(14);
        check("timer_fired", {31'd0, timer_irq}, 32'd1);
        wr(3'd5, 32'hFFFF_FFFF, 4'hF);
        wr(3'd4, 32'hFFFF_FFFE, 4'hF);
        check("timer_pre_wrap", {31'd0, timer_irq}, 32'd1);
        cycles(4);
        check("timer_after_wrap", {31'd0, timer_irq}, 32'd0);
        rd(3'd5, 32'd0, "mtime_hi_wrapped");
`else
        rd(3'd4, 32'd0, "unmapped_idx4");
        wr(3'd4, 32'hFFFF_FFFF, 4'hF);
        rd(3'd4, 32'd0, "unmapped_idx4_after_write");
        rd(3'd7, 32'd0, "unmapped_idx7");
        check("timer_tied_low", {31'd0, timer_irq}, 32'd0);
`endif

        cycles(3);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
